morse_keyer_decoder: RTL and testbench



---
 rtl/morse_pkg.sv | 29 ++
 rtl/morse_lookup.sv | 52 +++++
 rtl/morse_keyer_decoder.sv | 171 +++++++++++++++++
 tb/tb_morse_keyer_decoder.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/morse_pkg.sv
// Shared types and constants for the Morse keyer decoder and its lookup table.
package morse_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StMark,
        StGap,
        StWordWait
    } state_e;

    localparam int unsigned DashThDefault   = 2;
    localparam int unsigned LetterThDefault = 2;
    localparam int unsigned WordThDefault   = 5;

    localparam logic [7:0] AsciiSpace = 8'h20;
    localparam logic [7:0] AsciiErr   = 8'h3F;

    localparam logic ElemDot  = 1'b0;
    localparam logic ElemDash = 1'b1;

    localparam logic [2:0] MaxElems = 3'd5;

    // value bit i holds element i in send order
    typedef struct packed {
        logic [2:0] len;
        logic [4:0] value;
    } letter_t;

endpackage

// File: rtl/morse_lookup.sv
// Combinational {len, value} to ASCII for A-Z and 0-9; unknown patterns give '?'.
module morse_lookup
    import morse_pkg::*;
(
    input  letter_t    letter_i,
    output logic [6:0] ascii_o
);

    always_comb begin
        ascii_o = AsciiErr[6:0];
        case (letter_i)
            {3'd2, 5'd2}:  ascii_o = 7'h41; // A .-
            {3'd4, 5'd1}:  ascii_o = 7'h42; // B -...
            {3'd4, 5'd5}:  ascii_o = 7'h43; // C -.-.
            {3'd3, 5'd1}:  ascii_o = 7'h44; // D -..
            {3'd1, 5'd0}:  ascii_o = 7'h45; // E .
            {3'd4, 5'd4}:  ascii_o = 7'h46; // F ..-.
            {3'd3, 5'd3}:  ascii_o = 7'h47; // G --.
            {3'd4, 5'd0}:  ascii_o = 7'h48; // H ....
            {3'd2, 5'd0}:  ascii_o = 7'h49; // I ..
            {3'd4, 5'd14}: ascii_o = 7'h4A; // J .---
            {3'd3, 5'd5}:  ascii_o = 7'h4B; // K -.-
            {3'd4, 5'd2}:  ascii_o = 7'h4C; // L .-..
            {3'd2, 5'd3}:  ascii_o = 7'h4D; // M --
            {3'd2, 5'd1}:  ascii_o = 7'h4E; // N -.
            {3'd3, 5'd7}:  ascii_o = 7'h4F; // O ---
            {3'd4, 5'd6}:  ascii_o = 7'h50; // P .--.
            {3'd4, 5'd11}: ascii_o = 7'h51; // Q --.-
            {3'd3, 5'd2}:  ascii_o = 7'h52; // R .-.
            {3'd3, 5'd0}:  ascii_o = 7'h53; // S ...
            {3'd1, 5'd1}:  ascii_o = 7'h54; // T -
            {3'd3, 5'd4}:  ascii_o = 7'h55; // U ..-
            {3'd4, 5'd8}:  ascii_o = 7'h56; // V ...-
            {3'd3, 5'd6}:  ascii_o = 7'h57; // W .--
            {3'd4, 5'd9}:  ascii_o = 7'h58; // X -..-
            {3'd4, 5'd13}: ascii_o = 7'h59; // Y -.--
            {3'd4, 5'd3}:  ascii_o = 7'h5A; // Z --..
            {3'd5, 5'd31}: ascii_o = 7'h30; // 0 -----
            {3'd5, 5'd30}: ascii_o = 7'h31; // 1 .----
            {3'd5, 5'd28}: ascii_o = 7'h32; // 2 ..---
            {3'd5, 5'd24}: ascii_o = 7'h33; // 3 ...--
            {3'd5, 5'd16}: ascii_o = 7'h34; // 4 ....-
            {3'd5, 5'd0}:  ascii_o = 7'h35; // 5 .....
            {3'd5, 5'd1}:  ascii_o = 7'h36; // 6 -....
            {3'd5, 5'd3}:  ascii_o = 7'h37; // 7 --...
            {3'd5, 5'd7}:  ascii_o = 7'h38; // 8 ---..
            {3'd5, 5'd15}: ascii_o = 7'h39; // 9 ----.
            default:       ascii_o = AsciiErr[6:0];
        endcase
    end

endmodule

// File: rtl/morse_keyer_decoder.sv
// Hand-key Morse decoder: sync, debounce, unit timing, letter assembly, ASCII strobes.
// Optional sidetone output (debounced key level) when MORSE_SIDETONE_EN is defined.
module morse_keyer_decoder
    import morse_pkg::*;
#(
    parameter int unsigned CLK_UNITS       = 2_400_000,
    parameter int unsigned DEBOUNCE_CYCLES = 240_000,
    parameter int unsigned DASH_TH         = DashThDefault,
    parameter int unsigned LETTER_TH       = LetterThDefault,
    parameter int unsigned WORD_TH         = WordThDefault
) (
    input  logic       clk_24,
    input  logic       rst,
    input  logic       key_in,
    output logic       char_valid,
    output logic [7:0] char_data,
    output logic       busy
`ifdef MORSE_SIDETONE_EN
    ,
    output logic       sidetone
`endif
);

    localparam int unsigned CycW = (CLK_UNITS > 1) ? $clog2(CLK_UNITS) : 1;
    localparam int unsigned DbW  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CycW-1:0] CycLast  = CycW'(CLK_UNITS - 1);
    localparam logic [DbW-1:0]  DbLast   = DbW'(DEBOUNCE_CYCLES - 1);
    localparam logic [2:0]      DashThU  = 3'(DASH_TH);
    localparam logic [2:0]      LetterTh = 3'(LETTER_TH);
    localparam logic [2:0]      WordTh   = 3'(WORD_TH);

    logic [1:0]      sync_q, sync_d;
    logic [DbW-1:0]  db_cnt_q, db_cnt_d;
    logic            key_db_q, key_db_d;
    logic [CycW-1:0] cyc_q, cyc_d;
    logic [2:0]      units_q, units_d;
    state_e          state_q, state_d;
    letter_t         letter_q, letter_d;
    logic            err_q, err_d;
    logic            char_valid_q, char_valid_d;
    logic [7:0]      char_data_q, char_data_d;
    logic            busy_q, busy_d;

    logic       db_flip, key_press, key_release, unit_wrap;
    logic [2:0] units_now;
    logic [6:0] lookup_ascii;

    morse_lookup u_lookup (
        .letter_i (letter_q),
        .ascii_o  (lookup_ascii)
    );

    always_comb begin
        sync_d   = {sync_q[0], key_in};
        db_cnt_d = '0;
        key_db_d = key_db_q;
        db_flip  = 1'b0;
        if (sync_q[1] != key_db_q) begin
            if (db_cnt_q == DbLast) begin
                db_flip  = 1'b1;
                key_db_d = sync_q[1];
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
        key_press   = db_flip & sync_q[1];
        key_release = db_flip & ~sync_q[1];
    end

    // units_now counts a unit completing in this very cycle, so an exact N-unit mark reads N
    always_comb begin
        unit_wrap = (cyc_q == CycLast);
        units_now = (unit_wrap && units_q != 3'd7) ? units_q + 3'd1 : units_q;
        if (db_flip) begin
            cyc_d   = '0;
            units_d = '0;
        end else if (unit_wrap) begin
            cyc_d   = '0;
            units_d = units_now;
        end else begin
            cyc_d   = cyc_q + 1'b1;
            units_d = units_q;
        end
    end

    always_comb begin
        state_d      = state_q;
        letter_d     = letter_q;
        err_d        = err_q;
        char_valid_d = 1'b0;
        char_data_d  = char_data_q;
        unique case (state_q)
            StIdle: begin
                if (key_press) begin
                    state_d  = StMark;
                    letter_d = '0;
                    err_d    = 1'b0;
                end
            end
            StMark: begin
                if (key_release) begin
                    if (letter_q.len == MaxElems) begin
                        err_d = 1'b1;
                    end else begin
                        letter_d.value[letter_q.len] = (units_now >= DashThU) ? ElemDash : ElemDot;
                        letter_d.len = letter_q.len + 3'd1;
                    end
                    state_d = StGap;
                end
            end
            StGap: begin
                if (key_press) begin
                    state_d = StMark;
                end else if (units_q >= LetterTh) begin
                    char_valid_d = 1'b1;
                    char_data_d  = err_q ? AsciiErr : {1'b0, lookup_ascii};
                    state_d      = StWordWait;
                end
            end
            StWordWait: begin
                if (key_press) begin
                    state_d  = StMark;
                    letter_d = '0;
                    err_d    = 1'b0;
                end else if (units_q >= WordTh) begin
                    char_valid_d = 1'b1;
                    char_data_d  = AsciiSpace;
                    state_d      = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        busy_d = (state_d == StMark) || (state_d == StGap);
    end

    always_ff @(posedge clk_24) begin
        if (rst) begin
            sync_q       <= '0;
            db_cnt_q     <= '0;
            key_db_q     <= 1'b0;
            cyc_q        <= '0;
            units_q      <= '0;
            state_q      <= StIdle;
            letter_q     <= '0;
            err_q        <= 1'b0;
            char_valid_q <= 1'b0;
            char_data_q  <= '0;
            busy_q       <= 1'b0;
        end else begin
            sync_q       <= sync_d;
            db_cnt_q     <= db_cnt_d;
            key_db_q     <= key_db_d;
            cyc_q        <= cyc_d;
            units_q      <= units_d;
            state_q      <= state_d;
            letter_q     <= letter_d;
            err_q        <= err_d;
            char_valid_q <= char_valid_d;
            char_data_q  <= char_data_d;
            busy_q       <= busy_d;
        end
    end

    assign char_valid = char_valid_q;
    assign char_data  = char_data_q;
    assign busy       = busy_q;
`ifdef MORSE_SIDETONE_EN
    assign sidetone   = key_db_q;
`endif

endmodule

// File: tb/tb_morse_keyer_decoder.sv
// Self-checking bench for morse_keyer_decoder with short unit and debounce periods.
module tb_morse_keyer_decoder;

    localparam int unsigned Unit = 10;
    localparam int unsigned Db   = 3;

    logic       clk_24 = 1'b0;
    logic       rst    = 1'b1;
    logic       key_in = 1'b0;
    logic       char_valid;
    logic [7:0] char_data;
    logic       busy;
`ifdef MORSE_SIDETONE_EN
    logic       sidetone;
`endif

    morse_keyer_decoder #(
        .CLK_UNITS       (Unit),
        .DEBOUNCE_CYCLES (Db),
        .DASH_TH         (2),
        .LETTER_TH       (2),
        .WORD_TH         (5)
    ) dut (
        .clk_24     (clk_24),
        .rst        (rst),
        .key_in     (key_in),
        .char_valid (char_valid),
        .char_data  (char_data),
        .busy       (busy)
`ifdef MORSE_SIDETONE_EN
        ,
        .sidetone   (sidetone)
`endif
    );

    always #5 clk_24 = ~clk_24;

    int cyc = 0;
    always @(posedge clk_24) cyc <= cyc + 1;

    logic [7:0] strobe_data[$];
    int         strobe_cyc[$];
    logic       watch_en   = 1'b0;
    logic       busy_seen  = 1'b0;

    always @(negedge clk_24) begin
        if (char_valid) begin
            strobe_data.push_back(char_data);
            strobe_cyc.push_back(cyc);
        end
        if (watch_en && busy) busy_seen = 1'b1;
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h (%0d), expected 0x%0h (%0d)", name, act, act, exp, exp);
        end
    endtask

    function automatic int strobe_at(input int i);
        return (i < strobe_data.size()) ? int'(strobe_data[i]) : -1;
    endfunction

    function automatic int strobe_time(input int i);
        return (i < strobe_cyc.size()) ? strobe_cyc[i] : -1;
    endfunction

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk_24);
    endtask

    task automatic clear_strobes();
        strobe_data.delete();
        strobe_cyc.delete();
    endtask

    // elements 1 unit apart; key left released after the last one
    task automatic send_letter(input int len, input logic [5:0] pat);
        for (int i = 0; i < len; i++) begin
            key_in = 1'b1;
            wait_cycles((pat[i] ? 3 : 1) * Unit);
            key_in = 1'b0;
            if (i != len - 1) wait_cycles(Unit);
        end
    endtask

    typedef struct {
        string      name;
        int         len;
        logic [5:0] pat;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[13];

    initial begin
        int t0;

        vecs[0]  = '{"A",      2, 6'd2,  8'h41};
        vecs[1]  = '{"E",      1, 6'd0,  8'h45};
        vecs[2]  = '{"T",      1, 6'd1,  8'h54};
        vecs[3]  = '{"S",      3, 6'd0,  8'h53};
        vecs[4]  = '{"O",      3, 6'd7,  8'h4F};
        vecs[5]  = '{"K",      3, 6'd5,  8'h4B};
        vecs[6]  = '{"Q",      4, 6'd11, 8'h51};
        vecs[7]  = '{"Y",      4, 6'd13, 8'h59};
        vecs[8]  = '{"0",      5, 6'd31, 8'h30};
        vecs[9]  = '{"5",      5, 6'd0,  8'h35};
        vecs[10] = '{"9",      5, 6'd15, 8'h39};
        vecs[11] = '{"6dots",  6, 6'd0,  8'h3F};
        vecs[12] = '{"unknown",4, 6'd12, 8'h3F};

        wait_cycles(3);
        check("reset_valid", int'(char_valid), 0);
        check("reset_data",  int'(char_data),  0);
        check("reset_busy",  int'(busy),       0);
        rst = 1'b0;

        // idle after reset, then '5': no leading space
        wait_cycles(10 * Unit);
        check("idle_no_strobe", strobe_data.size(), 0);
        send_letter(5, 6'd0);
        wait_cycles(80);
        check("idle5_count", strobe_data.size(), 2);
        check("idle5_char",  strobe_at(0), 8'h35);
        check("idle5_space", strobe_at(1), 8'h20);

        foreach (vecs[k]) begin
            clear_strobes();
            send_letter(vecs[k].len, vecs[k].pat);
            wait_cycles(40);
            check({vecs[k].name, "_letter_count"}, strobe_data.size(), 1);
            check({vecs[k].name, "_char"}, strobe_at(0), int'(vecs[k].exp));
            check({vecs[k].name, "_busy_after"}, int'(busy), 0);
            wait_cycles(40);
            check({vecs[k].name, "_count"}, strobe_data.size(), 2);
            check({vecs[k].name, "_space"}, strobe_at(1), 8'h20);
        end

        // emission timing: letter 2 units and space 5 units into the gap, plus sync/debounce
        clear_strobes();
        send_letter(1, 6'd0);
        t0 = cyc;
        wait_cycles(300);
        check("e_timing_count", strobe_data.size(), 2);
        check("e_letter_time",  strobe_time(0) - t0, 26);
        check("e_space_time",   strobe_time(1) - t0, 56);
        check("e_timing_char",  strobe_at(0), 8'h45);

        // short glitches must be rejected entirely
        clear_strobes();
        busy_seen = 1'b0;
        watch_en  = 1'b1;
        for (int g = 0; g < 3; g++) begin
            key_in = 1'b1;
            wait_cycles(2);
            key_in = 1'b0;
            wait_cycles(6);
        end
        wait_cycles(40);
        watch_en = 1'b0;
        check("glitch_busy",    int'(busy_seen), 0);
        check("glitch_strobes", strobe_data.size(), 0);
        key_in = 1'b1;
        wait_cycles(4);
        key_in = 1'b0;
        wait_cycles(80);
        check("pulse4_count", strobe_data.size(), 2);
        check("pulse4_char",  strobe_at(0), 8'h45);

        // reset in the middle of a dash discards it
        clear_strobes();
        key_in = 1'b1;
        wait_cycles(15);
        check("mark_busy", int'(busy), 1);
`ifdef MORSE_SIDETONE_EN
        check("sidetone_on", int'(sidetone), 1);
`endif
        rst    = 1'b1;
        key_in = 1'b0;
        wait_cycles(1);
        rst = 1'b0;
        check("midrst_valid", int'(char_valid), 0);
        check("midrst_data",  int'(char_data),  0);
        check("midrst_busy",  int'(busy),       0);
        wait_cycles(80);
        check("midrst_no_strobe", strobe_data.size(), 0);
        send_letter(1, 6'd1);
        wait_cycles(80);
        check("post_rst_count", strobe_data.size(), 2);
        check("post_rst_T",     strobe_at(0), 8'h54);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
